// File: rtl/avg_speed_calc.sv
// Trip average-speed unit: distance * time-base constant / elapsed time via an
// internal restoring divider. Define AVG_SPEED_DECIMAL_EN for tenths-of-a-unit output.
module avg_speed_calc #(
    parameter int DIST_W    = 16,
    parameter int TIME_W    = 13,
    parameter int OUT_W     = 10,
    parameter int MAX_OUT   = 999,
    parameter int SEC_LIMIT = 6000,
    parameter int CONST_SEC = 3600,
    parameter int CONST_MIN = 60
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              start,
    input  logic [DIST_W-1:0] trip_distance,
    input  logic [TIME_W-1:0] trip_time_sec,
    input  logic [TIME_W-1:0] trip_time_min,
    output logic [OUT_W-1:0]  avg_speed,
    output logic              busy,
    output logic              valid,
    output logic              div_zero
);

    localparam int NUM_W = DIST_W + 16;
    localparam int CNT_W = $clog2(NUM_W);

`ifdef AVG_SPEED_DECIMAL_EN
    localparam int MUL_SEC = CONST_SEC * 10;
    localparam int MUL_MIN = CONST_MIN * 10;
`else
    localparam int MUL_SEC = CONST_SEC;
    localparam int MUL_MIN = CONST_MIN;
`endif

    localparam logic [NUM_W-1:0] MUL_SEC_V = NUM_W'(MUL_SEC);
    localparam logic [NUM_W-1:0] MUL_MIN_V = NUM_W'(MUL_MIN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DIV,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_W-1:0]   num_q, num_d;
    logic [NUM_W-1:0]   rem_q, rem_d;
    logic [TIME_W-1:0]  den_q, den_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   avg_q, avg_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;
    logic               divz_q, divz_d;

    logic               sel_min;
    logic [TIME_W-1:0]  den_sel;
    logic [NUM_W-1:0]   num_sel;
    logic [NUM_W-1:0]   r_shift;
    logic               r_ge;

    function automatic logic [OUT_W-1:0] sat_out(input logic [NUM_W-1:0] q);
        if (q > NUM_W'(MAX_OUT)) begin
            return OUT_W'(MAX_OUT);
        end
        return q[OUT_W-1:0];
    endfunction

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        rem_d   = rem_q;
        den_d   = den_q;
        cnt_d   = cnt_q;
        avg_d   = avg_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        divz_d  = divz_q;

        sel_min = (trip_time_sec >= TIME_W'(SEC_LIMIT));
        den_sel = sel_min ? trip_time_min : trip_time_sec;
        num_sel = NUM_W'(trip_distance) * (sel_min ? MUL_MIN_V : MUL_SEC_V);

        // num_q doubles as the quotient: dividend bits shift out, quotient bits shift in.
        // The remainder's top bit catches the case where the shifted value overflows NUM_W.
        r_shift = {rem_q[NUM_W-2:0], num_q[NUM_W-1]};
        r_ge    = rem_q[NUM_W-1] | (r_shift >= NUM_W'(den_q));

        if (!en) begin
            valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_LOAD;
                        valid_d = 1'b0;
                        busy_d  = 1'b1;
                    end
                end
                S_LOAD: begin
                    den_d = den_sel;
                    rem_d = '0;
                    if (den_sel == '0) begin
                        num_d   = '0;
                        divz_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        num_d   = num_sel;
                        divz_d  = 1'b0;
                        cnt_d   = CNT_W'(NUM_W - 1);
                        state_d = S_DIV;
                    end
                end
                S_DIV: begin
                    rem_d = r_ge ? (r_shift - NUM_W'(den_q)) : r_shift;
                    num_d = {num_q[NUM_W-2:0], r_ge};
                    if (cnt_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_DONE: begin
                    avg_d   = sat_out(num_q);
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            num_q   <= '0;
            rem_q   <= '0;
            den_q   <= '0;
            cnt_q   <= '0;
            avg_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            divz_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            rem_q   <= rem_d;
            den_q   <= den_d;
            cnt_q   <= cnt_d;
            avg_q   <= avg_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            divz_q  <= divz_d;
        end
    end

    assign avg_speed = avg_q;
    assign busy      = busy_q;
    assign valid     = valid_q;
    assign div_zero  = divz_q;

endmodule

// File: tb/tb_avg_speed_calc.sv
// Randomized and directed bench for avg_speed_calc with a cycle-level arithmetic reference.
module tb_avg_speed_calc;

    localparam int NUM_W     = 32;
    localparam int MAX_OUT   = 999;
    localparam int SEC_LIMIT = 6000;
`ifdef AVG_SPEED_DECIMAL_EN
    localparam longint MSEC = 36000;
    localparam longint MMIN = 600;
`else
    localparam longint MSEC = 3600;
    localparam longint MMIN = 60;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        start;
    logic [15:0] trip_distance;
    logic [12:0] trip_time_sec;
    logic [12:0] trip_time_min;
    logic [9:0]  avg_speed;
    logic        busy;
    logic        valid;
    logic        div_zero;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    avg_speed_calc dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .start         (start),
        .trip_distance (trip_distance),
        .trip_time_sec (trip_time_sec),
        .trip_time_min (trip_time_min),
        .avg_speed     (avg_speed),
        .busy          (busy),
        .valid         (valid),
        .div_zero      (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: phase 0 idle, 1 sampling inputs, 2 counting down to the result edge.
    int     m_phase = 0;
    int     m_left  = 0;
    longint m_res   = 0;
    longint m_avg   = 0;
    bit     m_busy  = 0;
    bit     m_valid = 0;
    bit     m_dz    = 0;

    always @(posedge clk or negedge rst) begin
        longint num, den;
        if (!rst) begin
            m_phase = 0; m_left = 0; m_res = 0; m_avg = 0;
            m_busy = 0; m_valid = 0; m_dz = 0;
        end else if (!en) begin
            m_valid = 0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_phase = 1; m_valid = 0; m_busy = 1;
                end
                1: begin
                    if (longint'(trip_time_sec) >= SEC_LIMIT) begin
                        num = longint'(trip_distance) * MMIN;
                        den = longint'(trip_time_min);
                    end else begin
                        num = longint'(trip_distance) * MSEC;
                        den = longint'(trip_time_sec);
                    end
                    if (den == 0) begin
                        m_res = 0; m_dz = 1; m_left = 1;
                    end else begin
                        m_res = num / den; m_dz = 0; m_left = NUM_W + 1;
                    end
                    m_phase = 2;
                end
                default: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_avg   = (m_res > MAX_OUT) ? MAX_OUT : m_res;
                        m_valid = 1; m_busy = 0; m_phase = 0;
                    end
                end
            endcase
        end
    end

    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            chk("cyc_valid", longint'(valid), longint'(m_valid));
            chk("cyc_busy", longint'(busy), longint'(m_busy));
            chk("cyc_div_zero", longint'(div_zero), longint'(m_dz));
            chk("cyc_avg", longint'(avg_speed), m_avg);
        end
    end

    task automatic run_one(input string name, input int d, input int s, input int m,
                           input int exp_avg, input int exp_dz, input int exp_lat,
                           input int xstart, input int en_off, input int en_on);
        int lat;
        @(negedge clk);
        trip_distance = 16'(d);
        trip_time_sec = 13'(s);
        trip_time_min = 13'(m);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        while (1) begin
            @(posedge clk);
            lat++;
            #1;
            if (valid) break;
            if (lat == 300) break;
            if (lat == xstart) start = 1'b1;
            if (lat == xstart + 1) start = 1'b0;
            if (lat == en_off) en = 1'b0;
            if (lat == en_on) en = 1'b1;
            if (en_off > 0 && lat > en_off && lat < en_on) chk({name, "_valid_en_low"}, longint'(valid), 0);
        end
        start = 1'b0;
        chk({name, "_valid"}, longint'(valid), 1);
        chk({name, "_latency"}, longint'(lat), longint'(exp_lat));
        chk({name, "_avg"}, longint'(avg_speed), longint'(exp_avg));
        chk({name, "_div_zero"}, longint'(div_zero), longint'(exp_dz));
        chk({name, "_busy"}, longint'(busy), 0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; start = 1'b0;
        trip_distance = '0; trip_time_sec = '0; trip_time_min = '0;
        #2 rst = 1'b0;
        #1;
        chk("reset_avg", longint'(avg_speed), 0);
        chk("reset_valid", longint'(valid), 0);
        chk("reset_busy", longint'(busy), 0);
        chk("reset_div_zero", longint'(div_zero), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        chk_en = 1'b1;

`ifdef AVG_SPEED_DECIMAL_EN
        run_one("dec_basic", 5, 600, 0, 300, 0, 34, -10, -10, -10);
        run_one("dec_sat", 50, 600, 0, 999, 0, 34, -10, -10, -10);
        run_one("dec_min", 100, 7200, 120, 500, 0, 34, -10, -10, -10);
        run_one("dec_sec_edge", 100, 5999, 120, 600, 0, 34, -10, -10, -10);
`else
        run_one("sec_basic", 50, 600, 0, 300, 0, 34, -10, -10, -10);
        run_one("min_mode", 100, 7200, 120, 50, 0, 34, -10, -10, -10);
        run_one("sec_edge", 100, 5999, 120, 60, 0, 34, -10, -10, -10);
`endif
        run_one("zero_time", 77, 0, 5, 0, 1, 2, -10, -10, -10);
        run_one("saturate", 500, 60, 0, 999, 0, 34, -10, -10, -10);
        run_one("min_zero", 40, 6000, 0, 0, 1, 2, -10, -10, -10);
`ifdef AVG_SPEED_DECIMAL_EN
        run_one("restart_ign", 5, 600, 0, 300, 0, 34, 5, -10, -10);
        run_one("en_pause", 5, 600, 0, 300, 0, 44, -10, 8, 18);
`else
        run_one("restart_ign", 50, 600, 0, 300, 0, 34, 5, -10, -10);
        run_one("en_pause", 50, 600, 0, 300, 0, 44, -10, 8, 18);
`endif
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("en_low_clears_valid", longint'(valid), 0);
        chk("en_low_holds_avg", longint'(avg_speed), 300);
        en = 1'b1;

        // Asynchronous reset in the middle of a division
        @(negedge clk);
        trip_distance = 16'd1234; trip_time_sec = 13'd100; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("async_rst_avg", longint'(avg_speed), 0);
        chk("async_rst_valid", longint'(valid), 0);
        chk("async_rst_busy", longint'(busy), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (40) @(posedge clk);
        #1 chk("no_valid_after_abort", longint'(valid), 0);
`ifdef AVG_SPEED_DECIMAL_EN
        run_one("after_reset", 5, 600, 0, 300, 0, 34, -10, -10, -10);
`else
        run_one("after_reset", 50, 600, 0, 300, 0, 34, -10, -10, -10);
`endif

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            en    = ($urandom_range(0, 9) != 0);
            start = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) begin
                trip_distance = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 65535))
                                                            : 16'($urandom_range(0, 300));
                case ($urandom_range(0, 4))
                    0:       trip_time_sec = 13'd0;
                    1:       trip_time_sec = 13'($urandom_range(1, 5999));
                    2:       trip_time_sec = 13'($urandom_range(6000, 8191));
                    3:       trip_time_sec = ($urandom_range(0, 1) == 0) ? 13'd5999 : 13'd6000;
                    default: trip_time_sec = 13'($urandom_range(1, 60));
                endcase
                trip_time_min = ($urandom_range(0, 3) == 0) ? 13'd0 : 13'($urandom_range(1, 8191));
            end
        end
        @(negedge clk);
        en = 1'b1; start = 1'b0;
        repeat (50) @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
